rs232_tx_arbiter: RTL

Sequencer and two-port arbiter in front of the RS232 transmitter. Two byte producers (CPU I/O register and debug monitor) push bytes via valid/ready into a shared FIFO under round-robin arbitration. A state machine drains the FIFO into the transmitter with its single-cycle `start`/`rdy` protocol, so neither producer needs to poll transmitter `rdy`.

---
 rtl/rs232_pkg.sv | 29 ++
 rtl/rs232_fifo.sv | 68 ++++++
 rtl/rs232_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg -- shared types and constants for the RS232 transmit arbiter.
//   tx_state_t : drain FSM states (IDLE, LOAD, GUARD, BUSY)
//   req_id_t   : requester id (0 = CPU I/O register, 1 = debug monitor)
//   DEF_DEPTH / DEF_CNTW : default FIFO depth and statistics counter width
//   TAG_W      : source-tag bits stored per FIFO entry (1 only when
//                RS232_TX_ARBITER_STATS_EN is defined, else 0)
`timescale 1ns/1ps
package rs232_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_CNTW  = 16;
    localparam int DATA_W    = 8;

`ifdef RS232_TX_ARBITER_STATS_EN
    localparam int TAG_W = 1;
`else
    localparam int TAG_W = 0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GUARD,
        BUSY
    } tx_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo -- synchronous FIFO holding byte + optional source tag.
//   Parameters: DEPTH (power of two), DW (data bits), TAGW (tag bits, may be 0)
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : write an entry (ignored when full)
//   pop, rdata   : rdata shows the head entry combinationally; pop advances it
//                  (ignored when empty)
//   count        : entries held, 0..DEPTH
//   full, empty  : decoded from the registered count
`timescale 1ns/1ps
module rs232_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int TAGW  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW+TAGW-1:0]       wdata,
    input  logic                     pop,
    output logic [DW+TAGW-1:0]       rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + TAGW;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset: contents are only visible through rd_ptr
    // once count says they were written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter -- two-port round-robin arbiter + FIFO + drain FSM in
// front of the RS232 transmitter.
//   clk, rst                  : 25 MHz clock, asynchronous active-high reset
//   reqN_valid/data/ready     : producer byte handshakes (N = 0, 1)
//   tx_start, tx_data         : one-cycle start pulse and byte to transmitter
//   tx_rdy                    : transmitter idle
//   fifo_count                : bytes queued
//   idle                      : FIFO empty, FSM idle and transmitter idle
//   cnt0, cnt1                : bytes sent per requester, only when
//                               RS232_TX_ARBITER_STATS_EN is defined
`timescale 1ns/1ps
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [7:0]             req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [7:0]             req1_data,
    output logic                   req1_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_rdy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   idle
`ifdef RS232_TX_ARBITER_STATS_EN
   ,output logic [CNTW-1:0]        cnt0,
    output logic [CNTW-1:0]        cnt1
`endif
);

    localparam int EW = DATA_W + TAG_W;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || CNTW < 1) begin : g_bad_param
        $error("rs232_tx_arbiter: DEPTH must be a power of two in 2..256 and CNTW >= 1");
    end

    logic          full;
    logic          empty;
    logic          gnt0;
    logic          gnt1;
    logic          push;
    logic          pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    req_id_t       prio;
    tx_state_t     state;
    tx_state_t     state_nx;

    // ---------------------------------------------------------------
    // Arbitration: full comes from the registered count, so a pop in the
    // same cycle never lets a push through early.
    // ---------------------------------------------------------------
    assign gnt0       = ~full & req0_valid & (~prio | ~req1_valid);
    assign gnt1       = ~full & req1_valid & ( prio | ~req0_valid);
    assign push       = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

`ifdef RS232_TX_ARBITER_STATS_EN
    assign wdata = {req_id_t'(gnt1), (gnt0 ? req0_data : req1_data)};
`else
    assign wdata = gnt0 ? req0_data : req1_data;
`endif

    // Priority passes to the other requester after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= 1'b0;
        else if (push)
            prio <= ~prio;
    end

    rs232_fifo #(
        .DEPTH (DEPTH),
        .DW    (DATA_W),
        .TAGW  (TAG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // ---------------------------------------------------------------
    // Drain FSM. IDLE only leaves on a registered non-empty count, so a
    // byte pushed into an empty FIFO is never popped in the same cycle.
    // GUARD covers the cycle where the transmitter still reports rdy after
    // accepting start.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (~empty & tx_rdy)
                    state_nx = LOAD;
            end
            LOAD: begin
                tx_start = 1'b1;
                tx_data  = rdata[DATA_W-1:0];
                pop      = 1'b1;
                state_nx = GUARD;
            end
            GUARD: begin
                state_nx = BUSY;
            end
            BUSY: begin
                if (tx_rdy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign idle = empty & (state == IDLE) & tx_rdy;

`ifdef RS232_TX_ARBITER_STATS_EN
    // Count on the popped entry's tag; counters wrap at 2^CNTW.
    req_id_t pop_src;
    assign pop_src = rdata[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (pop) begin
            if (pop_src)
                cnt1 <= cnt1 + 1'b1;
            else
                cnt0 <= cnt0 + 1'b1;
        end
    end
`endif

endmodule
